// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo_param FIFO family.
//   fifo_mode_e : read-mode encodings (registered vs first-word-fall-through)
//   ptr_width   : pointer width for a given address width (one extra wrap bit)
package fifo_pkg;

  typedef enum logic {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/bus bundle between a producer/consumer and sync_fifo_param.
//   master : drives wr_en, wr_data, rd_en; observes data, flags, count, errors
//   slave  : the FIFO side, the mirror image of master
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) ();

  logic                               wr_en;
  logic [DATA_WIDTH-1:0]              wr_data;
  logic                               rd_en;
  logic [DATA_WIDTH-1:0]              rd_data;
  logic                               rd_valid;
  logic                               full;
  logic                               empty;
  logic                               almost_full;
  logic                               almost_empty;
  logic [ptr_width(ADDR_WIDTH)-1:0]   count;
  logic                               overflow;
  logic                               underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_dpram.sv
// Simple dual-port storage for the FIFO: synchronous write port,
// asynchronous read port, 2**ADDR_WIDTH words, no reset.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write word
//   rd_addr : read address
//   rd_data : read word (combinational from rd_addr)
module fifo_dpram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered or FWFT read mode,
// occupancy count, almost-full/almost-empty thresholds and
// overflow/underflow error pulses.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset (pointers/outputs cleared, memory kept)
//   fifo : slave side of sync_fifo_param_if (wr_en/wr_data/rd_en in;
//          rd_data/rd_valid/full/empty/almost_*/count/overflow/underflow out)
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 1,
  parameter int AE_THRESH  = 1
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave fifo
);

  localparam int PW      = ptr_width(ADDR_WIDTH);
  localparam bit IS_FWFT = (FWFT == int'(FIFO_MODE_FWFT));
  localparam logic [PW-1:0] AF_LEVEL = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LEVEL = PW'(AE_THRESH);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [PW-1:0]         count;
  logic                  empty, full;
  logic                  rd_accept, wr_accept;

  // Flags come only from registered pointers, so they never see wr_en/rd_en.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
            (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    count = wr_ptr_q - rd_ptr_q;
  end

  always_comb begin
    rd_accept   = fifo.rd_en && !empty;
    // A read on the same edge frees the slot, so a write at full still fits.
    wr_accept   = fifo.wr_en && (!full || rd_accept);

    wr_ptr_d    = wr_accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_accept ? rd_ptr_q + PW'(1) : rd_ptr_q;
    rd_data_d   = rd_accept ? mem_rd_data : rd_data_q;
    rd_valid_d  = rd_accept;
    overflow_d  = fifo.wr_en && !wr_accept;
    underflow_d = fifo.rd_en && !rd_accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (fifo.wr_data),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (mem_rd_data)
  );

  // FWFT presents the head word directly; registered mode uses the output flop.
  assign fifo.rd_data      = IS_FWFT ? mem_rd_data : rd_data_q;
  assign fifo.rd_valid     = IS_FWFT ? !empty : rd_valid_q;
  assign fifo.full         = full;
  assign fifo.empty        = empty;
  assign fifo.count        = count;
  assign fifo.almost_full  = (count >= AF_LEVEL);
  assign fifo.almost_empty = (count <= AE_LEVEL);
  assign fifo.overflow     = overflow_q;
  assign fifo.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_s ();
  sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_f ();

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FWFT       (0)
  ) u_std (
    .clk  (clk),
    .rst  (rst),
    .fifo (if_s)
  );

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FWFT       (1),
    .AF_THRESH  (3),
    .AE_THRESH  (1)
  ) u_fwft (
    .clk  (clk),
    .rst  (rst),
    .fifo (if_f)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [DW-1:0] sb_s [$];
  logic [DW-1:0] sb_f [$];
  int            m_cnt_s = 0;
  int            m_cnt_f = 0;
  logic [DW-1:0] last_s  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Registered-read instance: drive one cycle, then compare against the model.
  task automatic std_op(input bit wr, input logic [DW-1:0] d, input bit rd);
    bit ra, wa;
    ra = rd && (m_cnt_s > 0);
    wa = wr && ((m_cnt_s < DEPTH) || ra);
    if_s.wr_en   = wr;
    if_s.wr_data = d;
    if_s.rd_en   = rd;
    if (wa) sb_s.push_back(d);
    tick();
    if_s.wr_en = 1'b0;
    if_s.rd_en = 1'b0;
    m_cnt_s = m_cnt_s + int'(wa) - int'(ra);
    check("s_rd_valid", 32'(if_s.rd_valid), 32'(ra));
    if (ra) last_s = sb_s.pop_front();
    check("s_rd_data", 32'(if_s.rd_data), 32'(last_s));
    check("s_overflow", 32'(if_s.overflow), 32'(wr && !wa));
    check("s_underflow", 32'(if_s.underflow), 32'(rd && !ra));
    check("s_count", 32'(if_s.count), 32'(m_cnt_s));
    check("s_full", 32'(if_s.full), 32'(m_cnt_s == DEPTH));
    check("s_empty", 32'(if_s.empty), 32'(m_cnt_s == 0));
    check("s_almost_full", 32'(if_s.almost_full), 32'(m_cnt_s >= DEPTH - 1));
    check("s_almost_empty", 32'(if_s.almost_empty), 32'(m_cnt_s <= 1));
  endtask

  // FWFT instance: head must be visible without rd_en; rd_en consumes it.
  task automatic fw_op(input bit wr, input logic [DW-1:0] d, input bit rd);
    bit ra, wa;
    ra = rd && (m_cnt_f > 0);
    wa = wr && ((m_cnt_f < DEPTH) || ra);
    if (ra) check("f_head_pop", 32'(if_f.rd_data), 32'(sb_f.pop_front()));
    if_f.wr_en   = wr;
    if_f.wr_data = d;
    if_f.rd_en   = rd;
    if (wa) sb_f.push_back(d);
    tick();
    if_f.wr_en = 1'b0;
    if_f.rd_en = 1'b0;
    m_cnt_f = m_cnt_f + int'(wa) - int'(ra);
    check("f_rd_valid", 32'(if_f.rd_valid), 32'(m_cnt_f > 0));
    if (m_cnt_f > 0) check("f_head", 32'(if_f.rd_data), 32'(sb_f[0]));
    check("f_overflow", 32'(if_f.overflow), 32'(wr && !wa));
    check("f_underflow", 32'(if_f.underflow), 32'(rd && !ra));
    check("f_count", 32'(if_f.count), 32'(m_cnt_f));
    check("f_full", 32'(if_f.full), 32'(m_cnt_f == DEPTH));
    check("f_empty", 32'(if_f.empty), 32'(m_cnt_f == 0));
    check("f_almost_full", 32'(if_f.almost_full), 32'(m_cnt_f >= 3));
    check("f_almost_empty", 32'(if_f.almost_empty), 32'(m_cnt_f <= 1));
  endtask

  task automatic check_reset_std();
    check("rst_count", 32'(if_s.count), 32'd0);
    check("rst_empty", 32'(if_s.empty), 32'd1);
    check("rst_full", 32'(if_s.full), 32'd0);
    check("rst_rd_valid", 32'(if_s.rd_valid), 32'd0);
    check("rst_rd_data", 32'(if_s.rd_data), 32'd0);
    check("rst_overflow", 32'(if_s.overflow), 32'd0);
    check("rst_underflow", 32'(if_s.underflow), 32'd0);
    check("rst_almost_empty", 32'(if_s.almost_empty), 32'd1);
    check("rst_almost_full", 32'(if_s.almost_full), 32'd0);
    check("rst_f_count", 32'(if_f.count), 32'd0);
    check("rst_f_rd_valid", 32'(if_f.rd_valid), 32'd0);
  endtask

  initial begin
    if_s.wr_en = 1'b0; if_s.rd_en = 1'b0; if_s.wr_data = '0;
    if_f.wr_en = 1'b0; if_f.rd_en = 1'b0; if_f.wr_data = '0;

    #1 rst = 1'b1;
    #1 check_reset_std();
    tick();
    tick();
    rst = 1'b0;

    // Fill to full, then one rejected write.
    for (int i = 0; i < DEPTH; i++) std_op(1'b1, 8'hA0 + 8'(i), 1'b0);
    std_op(1'b1, 8'hA4, 1'b0);
    std_op(1'b0, 8'h00, 1'b0);
    // Drain in order.
    for (int i = 0; i < DEPTH; i++) std_op(1'b0, 8'h00, 1'b1);

    // Underflow on empty: pulse for one cycle, rd_data held.
    std_op(1'b0, 8'h00, 1'b1);
    std_op(1'b0, 8'h00, 1'b0);

    // Simultaneous read+write at full.
    for (int i = 0; i < DEPTH; i++) std_op(1'b1, 8'hB0 + 8'(i), 1'b0);
    std_op(1'b1, 8'hB4, 1'b1);
    for (int i = 0; i < DEPTH; i++) std_op(1'b0, 8'h00, 1'b1);

    // Simultaneous read+write at empty.
    std_op(1'b1, 8'hC0, 1'b1);
    std_op(1'b0, 8'h00, 1'b1);

    // Wrap-around through the pointer MSB.
    for (int i = 0; i < 10; i++) begin
      std_op(1'b1, 8'hD0 + 8'(i), 1'b0);
      std_op(1'b0, 8'h00, 1'b1);
    end

    // Random traffic.
    for (int i = 0; i < 60; i++)
      std_op(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < DEPTH; i++) std_op(1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-stream with three words stored.
    for (int i = 0; i < DEPTH; i++) std_op(1'b1, 8'hE0 + 8'(i), 1'b0);
    std_op(1'b0, 8'h00, 1'b1);
    rst = 1'b1;
    #1 check_reset_std();
    sb_s.delete();
    m_cnt_s = 0;
    last_s  = '0;
    #1 rst = 1'b0;
    // Write in the cycle straight after release is honoured.
    std_op(1'b1, 8'h3C, 1'b0);
    std_op(1'b0, 8'h00, 1'b1);

    // FWFT instance.
    fw_op(1'b1, 8'h55, 1'b0);
    fw_op(1'b1, 8'h66, 1'b0);
    fw_op(1'b1, 8'h77, 1'b0);
    fw_op(1'b1, 8'h88, 1'b0);
    fw_op(1'b1, 8'h99, 1'b0);
    fw_op(1'b1, 8'h9A, 1'b1);
    for (int i = 0; i < DEPTH; i++) fw_op(1'b0, 8'h00, 1'b1);
    fw_op(1'b0, 8'h00, 1'b1);
    fw_op(1'b1, 8'h12, 1'b1);
    for (int i = 0; i < 40; i++)
      fw_op(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
